alu_mul_sequencer: RTL and testbench

//  Multi-cycle 8x8 unsigned multiply controller that borrows the EX-stage binary ALU.

---
 rtl/alu_mul_sequencer.sv | 104 ++++++++++
 tb/tb_alu_mul_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// Sequential 8x8 unsigned shift-and-add multiplier that borrows the shared
// EX-stage ALU one add per granted cycle and returns a 16-bit product.
module alu_mul_sequencer #(
  parameter int unsigned DW     = 8,
  parameter int unsigned ITER   = 8,
  parameter int unsigned CTRL_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DW-1:0]     mcand,
  input  logic [DW-1:0]     mplier,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [2*DW-1:0]   product,
  output logic              alu_req,
  input  logic              alu_gnt,
  output logic              alu_en,
  output logic [DW-1:0]     alu_op1,
  output logic [DW-1:0]     alu_op2,
  output logic [0:CTRL_W-1] alu_ctrl,
  input  logic [DW-1:0]     alu_dout,
  input  logic              alu_cout
);

  localparam int unsigned CW = $clog2(ITER) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state, state_nx;
  logic [DW-1:0]   a_q, hi_q, lo_q;
  logic [CW-1:0]   cnt_q;
  logic            run, step, accept, last;
  logic [2*DW-1:0] shifted;

  assign run     = (state == S_RUN);
  assign step    = run && alu_gnt && !flush;
  assign accept  = !run && start && !flush;
  assign last    = (cnt_q == CW'(ITER - 1));
  // 17-bit {cout,sum,lo} shifted right by one; the dropped bit is lo[0]
  assign shifted = {alu_cout, alu_dout, lo_q[DW-1:1]};

  assign busy    = run;
  assign done    = (state == S_DONE);
  assign alu_req = run;

  // Next-state selection; flush overrides both iteration and start
  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state_nx = S_RUN;
        S_RUN:   if (alu_gnt && last) state_nx = S_DONE;
        S_DONE:  state_nx = start ? S_RUN : S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // ALU drive: all-zero unless this block owns the ALU in RUN
  always_comb begin
    alu_en   = run && alu_gnt;
    alu_op1  = '0;
    alu_op2  = '0;
    alu_ctrl = '0;
    if (run && alu_gnt) begin
      alu_op1     = hi_q;
      alu_op2     = lo_q[0] ? a_q : '0;
      alu_ctrl[0] = 1'b1;
    end
  end

  // State, datapath and product registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      product <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_q   <= mcand;
        hi_q  <= '0;
        lo_q  <= mplier;
        cnt_q <= '0;
      end else if (step) begin
        {hi_q, lo_q} <= shifted;
        cnt_q        <= cnt_q + CW'(1);
        if (last) product <= shifted;
      end
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench: reference is plain integer multiplication plus the
// closed-form partial products expected on the ALU operand buses.
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, flush, alu_gnt;
  logic [7:0]  mcand, mplier;
  logic        busy, done, alu_req, alu_en, alu_cout;
  logic [15:0] product;
  logic [7:0]  alu_op1, alu_op2, alu_dout;
  logic [0:13] alu_ctrl;

  int checks = 0;
  int failures = 0;

  alu_mul_sequencer #(.DW(8), .ITER(8), .CTRL_W(14)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mcand(mcand), .mplier(mplier),
    .flush(flush), .busy(busy), .done(done), .product(product),
    .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_en(alu_en),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl),
    .alu_dout(alu_dout), .alu_cout(alu_cout)
  );

  // Shared ALU stand-in: 8-bit adder with carry out
  assign {alu_cout, alu_dout} = {1'b0, alu_op1} + {1'b0, alu_op2};

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Runs from the first RUN cycle until done; checks every cycle.
  task automatic run_phase(input int a, input int b, input int stall_at,
                           input int stall_len, input bit rnd, input bit spam,
                           output bit cout_seen);
    int k = 0;
    int stalls = 0;
    int n = 1;
    bit g, fin;
    logic [0:13] ec;
    cout_seen = 1'b0;
    fin = 1'b0;
    while (n < 80 && !fin) begin
      if (rnd) g = ($urandom_range(0, 3) != 0);
      else     g = !(k == stall_at && stalls < stall_len);
      alu_gnt = g;
      if (spam) begin
        start = 1'b1; mcand = 8'd2; mplier = 8'd2;
      end else begin
        start = 1'b0;
      end
      #1;
      if (done) begin
        chk("latency", n, 9 + stalls);
        chk("iters", k, 8);
        chk("product", product, a * b);
        chk("done_busy", busy, 0);
        chk("done_req", alu_req, 0);
        chk("done_en", alu_en, 0);
        fin = 1'b1;
      end else begin
        chk("busy", busy, 1);
        chk("req", alu_req, 1);
        chk("en", alu_en, g);
        ec = '0;
        if (g) begin
          ec[0] = 1'b1;
          chk("op1", alu_op1, (a * (b & ((1 << k) - 1))) >> k);
          chk("op2", alu_op2, ((b >> k) & 1) ? a : 0);
          if (alu_cout) cout_seen = 1'b1;
          k++;
        end else begin
          stalls++;
          chk("stall_op1", alu_op1, 0);
          chk("stall_op2", alu_op2, 0);
        end
        chk("ctrl", alu_ctrl, ec);
        @(posedge clk);
        #2;
        n++;
      end
    end
    if (!fin) chk("timeout", 0, 1);
  endtask

  task automatic issue(input int a, input int b);
    start = 1'b1; mcand = 8'(a); mplier = 8'(b);
    alu_gnt = $urandom_range(0, 1);
    cyc();
    start = 1'b0;
  endtask

  task automatic do_mul(input int a, input int b, input int stall_at,
                        input int stall_len, input bit rnd, output bit cout_seen);
    issue(a, b);
    run_phase(a, b, stall_at, stall_len, rnd, 1'b0, cout_seen);
    cyc();
    #1;
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    bit cs;
    int cnt_done;
    int a, b;
    logic [15:0] prev;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; alu_gnt = 1'b1;
    mcand = 8'hFF; mplier = 8'hFF;

    // Reset values, with gnt high to show it is ignored outside RUN
    cyc(); cyc();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req", alu_req, 0);
    chk("rst_en", alu_en, 0);
    chk("rst_prod", product, 0);
    chk("rst_op1", alu_op1, 0);
    chk("rst_op2", alu_op2, 0);
    chk("rst_ctrl", alu_ctrl, 0);
    rst_n = 1'b1;
    cyc();

    do_mul(13, 11, -1, 0, 1'b0, cs);
    do_mul(255, 255, -1, 0, 1'b0, cs);
    chk("cout_seen", cs, 1);
    do_mul(8'h5A, 0, -1, 0, 1'b0, cs);
    do_mul(13, 11, 4, 3, 1'b0, cs);

    // start while busy ignored; start held into DONE is accepted
    issue(13, 11);
    run_phase(13, 11, -1, 0, 1'b0, 1'b1, cs);
    cyc();
    start = 1'b0;
    #1;
    chk("b2b_busy", busy, 1);
    chk("b2b_done", done, 0);
    #1;
    run_phase(2, 2, -1, 0, 1'b0, 1'b0, cs);
    cyc();

    // flush at iteration 5
    prev = product;
    issue(8'h37, 8'hC5);
    alu_gnt = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    #1;
    chk("fl_busy", busy, 0);
    chk("fl_done", done, 0);
    chk("fl_req", alu_req, 0);
    chk("fl_prod", product, prev);
    #1;
    flush = 1'b1; start = 1'b1;
    cyc();
    flush = 1'b0; start = 1'b0;
    #1;
    chk("fl_start_busy", busy, 0);
    cnt_done = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (done) cnt_done++;
    end
    chk("fl_no_done", cnt_done, 0);

    // reset at iteration 3
    issue(9, 7);
    alu_gnt = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    rst_n = 1'b0;
    cyc();
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_req", alu_req, 0);
    chk("mr_en", alu_en, 0);
    chk("mr_prod", product, 0);
    chk("mr_op1", alu_op1, 0);
    chk("mr_op2", alu_op2, 0);
    chk("mr_ctrl", alu_ctrl, 0);
    rst_n = 1'b1;
    cyc();

    // randomized operands and grant pattern
    for (int i = 0; i < 25; i++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      do_mul(a, b, -1, 0, 1'b1, cs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
